// File: rtl/bsg_demux_one_hot_buffered.sv
`default_nettype none
// ============================================================================
// Module      : bsg_demux_one_hot_buffered
// Description : Steers one input word to one of els_p output channels chosen
//               by a one-hot select. Every channel has its own 2-entry FIFO,
//               so each consumer drains independently using valid/yumi.
//               A valid word carrying a non-one-hot select is accepted and
//               dropped, and it sets a sticky error flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1              clock, rising edge
//   reset_n_i      in   1              asynchronous active-low reset
//   v_i            in   1              input word valid
//   data_i         in   width_p        input word
//   sel_one_hot_i  in   els_p          destination channel, one-hot
//   ready_o        out  1              word accepted when v_i & ready_o
//   v_o            out  els_p          per-channel FIFO head valid
//   data_o         out  els_p*width_p  channel i head at [i*width_p +: width_p]
//   yumi_i         in   els_p          per-channel dequeue of the head
//   err_o          out  1              sticky: valid word with bad select
// ============================================================================
module bsg_demux_one_hot_buffered #(
    parameter int width_p = 62,
    parameter int els_p   = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    input  logic [els_p-1:0]           sel_one_hot_i,
    output logic                       ready_o,
    output logic [els_p-1:0]           v_o,
    output logic [els_p*width_p-1:0]   data_o,
    input  logic [els_p-1:0]           yumi_i,
    output logic                       err_o
);

    localparam logic [1:0] c_CNT_FULL = 2'd2;

    // ------------------------------------------------------------------
    // Select decode
    // ------------------------------------------------------------------
    logic             w_sel_legal;
    logic             w_sel_full;
    logic [els_p-1:0] w_full;
    logic [els_p-1:0] w_enq;
    logic [els_p-1:0] w_deq;
    logic             r_err;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_sel_legal = (sel_one_hot_i != '0)
                       && ((sel_one_hot_i & (sel_one_hot_i - els_p'(1))) == '0);

    assign w_sel_full  = |(sel_one_hot_i & w_full);

    // A bad select always drains the producer so the word can be dropped.
    // ready_o never looks at yumi_i: a full FIFO is not refilled in the
    // cycle it is popped.
    assign ready_o = w_sel_legal ? ~w_sel_full : 1'b1;

    // ------------------------------------------------------------------
    // Sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err <= 1'b0;
        end else if (v_i && !w_sel_legal) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

    // ------------------------------------------------------------------
    // Per-channel 2-entry FIFOs
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_chan
            logic               r_wptr;
            logic               r_rptr;
            logic [1:0]         r_cnt;
            logic [width_p-1:0] r_mem [2];

            assign w_full[gi] = (r_cnt == c_CNT_FULL);
            assign v_o[gi]    = (r_cnt != 2'd0);
            assign w_enq[gi]  = v_i & w_sel_legal & sel_one_hot_i[gi] & ~w_full[gi];
            assign w_deq[gi]  = yumi_i[gi];

            // Head comes straight from storage; data_i never reaches data_o
            // combinationally.
            assign data_o[gi*width_p +: width_p] = r_mem[r_rptr];

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_wptr <= 1'b0;
                    r_rptr <= 1'b0;
                    r_cnt  <= 2'd0;
                end else begin
                    if (w_enq[gi]) begin
                        r_wptr <= ~r_wptr;
                    end
                    if (w_deq[gi]) begin
                        r_rptr <= ~r_rptr;
                    end
                    case ({w_enq[gi], w_deq[gi]})
                        2'b10:   r_cnt <= r_cnt + 2'd1;
                        2'b01:   r_cnt <= r_cnt - 2'd1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            // Storage contents are don't-care while empty, so no reset.
            always_ff @(posedge clk_i) begin
                if (w_enq[gi]) begin
                    r_mem[r_wptr] <= data_i;
                end
            end

`ifndef SYNTHESIS
            a_no_yumi_on_empty : assert property (
                @(posedge clk_i) disable iff (!reset_n_i)
                !(yumi_i[gi] && !v_o[gi])
            );
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bsg_demux_one_hot_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_demux_one_hot_buffered
// Description : Self-checking bench for bsg_demux_one_hot_buffered. A
//               reference model (one queue per channel plus a sticky error
//               bit) predicts ready_o, v_o, err_o and the data of each pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_demux_one_hot_buffered;

    localparam int W = 62;
    localparam int N = 2;

    logic             clk_i;
    logic             reset_n_i;
    logic             v_i;
    logic [W-1:0]     data_i;
    logic [N-1:0]     sel_one_hot_i;
    logic             ready_o;
    logic [N-1:0]     v_o;
    logic [N*W-1:0]   data_o;
    logic [N-1:0]     yumi_i;
    logic             err_o;

    int checks;
    int errors;

    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    logic         m_err;

    bsg_demux_one_hot_buffered #(
        .width_p (W),
        .els_p   (N)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .v_i           (v_i),
        .data_i        (data_i),
        .sel_one_hot_i (sel_one_hot_i),
        .ready_o       (ready_o),
        .v_o           (v_o),
        .data_o        (data_o),
        .yumi_i        (yumi_i),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          v;
        logic [N-1:0]  sel;
        logic [W-1:0]  d;
        logic [N-1:0]  y;
        logic          exp_rdy;
        logic [N-1:0]  exp_v;
        logic          exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [N-1:0] s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    task automatic set_in(input logic v, input logic [N-1:0] s, input logic [W-1:0] d,
                          input logic [N-1:0] y);
        v_i           = v;
        sel_one_hot_i = s;
        data_i        = d;
        yumi_i        = y;
    endtask

    // Inputs are already applied; check the pre-edge outputs against the
    // model, update the model, then advance past the next rising edge.
    task automatic cycle();
        logic lg;
        logic exp_rdy;
        int   depth;
        #1;
        lg    = is_legal(sel_one_hot_i);
        depth = sel_one_hot_i[1] ? q1.size() : q0.size();
        exp_rdy = lg ? (depth < 2) : 1'b1;
        chk("ready_o", 64'(ready_o), 64'(exp_rdy));
        chk("v_o", 64'(v_o), 64'({q1.size() != 0, q0.size() != 0}));
        chk("err_o", 64'(err_o), 64'(m_err));
        if (yumi_i[0]) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_ch0: model queue empty, got %h", data_o[W-1:0]);
            end else begin
                chk("data_ch0", 64'(data_o[W-1:0]), 64'(q0.pop_front()));
            end
        end
        if (yumi_i[1]) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_ch1: model queue empty, got %h", data_o[2*W-1:W]);
            end else begin
                chk("data_ch1", 64'(data_o[2*W-1:W]), 64'(q1.pop_front()));
            end
        end
        if (v_i && lg && exp_rdy) begin
            if (sel_one_hot_i[0]) q0.push_back(data_i);
            else                  q1.push_back(data_i);
        end
        if (v_i && !lg) m_err = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // Asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        reset_n_i = 1'b0;
        set_in(1'b0, '0, '0, '0);
        #1;
        chk("rst_async_v_o", 64'(v_o), 64'(0));
        chk("rst_async_err_o", 64'(err_o), 64'(0));
        q0.delete();
        q1.delete();
        m_err = 1'b0;
        @(posedge clk_i);
        #1;
        chk("rst_held_v_o", 64'(v_o), 64'(0));
        reset_n_i = 1'b1;
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_err     = 1'b0;
        reset_n_i = 1'b1;
        set_in(1'b0, '0, '0, '0);

        // Reset then idle
        #2;
        do_reset();
        set_in(1'b0, 2'b01, '0, '0);
        cycle();
        set_in(1'b0, 2'b10, '0, '0);
        cycle();

        // Single routing and illegal-select sequence from a table
        tbl[0] = '{1'b1, 2'b10, 62'h2A5A5A5A5A5A5A5, 2'b00, 1'b1, 2'b00, 1'b0};
        tbl[1] = '{1'b0, 2'b01, 62'h0,              2'b10, 1'b1, 2'b10, 1'b0};
        tbl[2] = '{1'b0, 2'b10, 62'h0,              2'b00, 1'b1, 2'b00, 1'b0};
        tbl[3] = '{1'b1, 2'b01, 62'h7,              2'b00, 1'b1, 2'b00, 1'b0};
        tbl[4] = '{1'b1, 2'b11, 62'h5,              2'b00, 1'b1, 2'b01, 1'b0};
        tbl[5] = '{1'b1, 2'b00, 62'h6,              2'b00, 1'b1, 2'b01, 1'b1};
        tbl[6] = '{1'b0, 2'b00, 62'h0,              2'b01, 1'b1, 2'b01, 1'b1};
        tbl[7] = '{1'b0, 2'b01, 62'h0,              2'b00, 1'b1, 2'b00, 1'b1};
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].y);
            #1;
            chk("tbl_ready", 64'(ready_o), 64'(tbl[i].exp_rdy));
            chk("tbl_v_o", 64'(v_o), 64'(tbl[i].exp_v));
            chk("tbl_err", 64'(err_o), 64'(tbl[i].exp_err));
            cycle();
        end

        // Only reset clears the sticky error
        do_reset();
        chk("err_cleared", 64'(err_o), 64'(0));

        // Fill and back-pressure on channel 0
        set_in(1'b1, 2'b01, 62'd1, 2'b00); cycle();
        set_in(1'b1, 2'b01, 62'd2, 2'b00); cycle();
        set_in(1'b1, 2'b01, 62'd3, 2'b00);
        #1; chk("full_ready_low", 64'(ready_o), 64'(0));
        cycle();
        set_in(1'b1, 2'b01, 62'd3, 2'b01);
        #1; chk("full_pop_ready_low", 64'(ready_o), 64'(0));
        cycle();
        set_in(1'b1, 2'b01, 62'd3, 2'b00);
        #1; chk("after_pop_ready_high", 64'(ready_o), 64'(1));
        cycle();
        set_in(1'b0, 2'b01, '0, 2'b01); cycle();
        set_in(1'b0, 2'b01, '0, 2'b01); cycle();
        set_in(1'b0, 2'b01, '0, 2'b00); cycle();

        // Concurrent traffic on both channels, consumers always draining
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, W'(k), v_o);
            #1; chk("concurrent_no_stall", 64'(ready_o), 64'(1));
            cycle();
        end
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 2'b01, '0, v_o);
            cycle();
        end
        chk("concurrent_drained", 64'(v_o), 64'(0));

        // Reset with both FIFOs full, then confirm no stale words emerge
        set_in(1'b1, 2'b01, 62'hA0, 2'b00); cycle();
        set_in(1'b1, 2'b10, 62'hB0, 2'b00); cycle();
        set_in(1'b1, 2'b01, 62'hA1, 2'b00); cycle();
        set_in(1'b1, 2'b10, 62'hB1, 2'b00); cycle();
        chk("both_full", 64'(v_o), 64'(2'b11));
        do_reset();
        set_in(1'b1, 2'b01, 62'h3FFF_0000_ABCD, 2'b00); cycle();
        set_in(1'b1, 2'b10, 62'h1234_5678_9ABC, 2'b00); cycle();
        set_in(1'b0, 2'b01, '0, 2'b11); cycle();
        set_in(1'b0, 2'b01, '0, 2'b00); cycle();

        if (q0.size() != 0 || q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL leftover_model_words: ch0 %0d ch1 %0d expected 0", q0.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/bsg_demux_one_hot_buffered.md
Name: bsg_demux_one_hot_buffered

Overview:
- Inverse of the one-hot data mux: steers one width_p-bit input word to one of els_p output channels, selected by a one-hot vector.
- Each output channel has a 2-entry FIFO, so each consumer drains independently with valid/yumi.
- Sits between a shared producer (e.g. a response bus) and per-requester consumers in the cache/NoC datapath.

Parameters:
- width_p, 62, bits per data word.
- els_p, 2, number of output channels (≥2).

Ports:
- clk_i  input  1  clock; all state on rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- v_i  input  1  input word valid.
- data_i  input  width_p  input word.
- sel_one_hot_i  input  els_p  destination channel, one-hot; sampled with v_i.
- ready_o  output  1  input accepted this cycle when v_i & ready_o.
- v_o  output  els_p  bit i: channel i FIFO head valid.
- data_o  output  els_p*width_p  channel i head at data_o[i*width_p +: width_p]; channel 0 in the low bits.
- yumi_i  input  els_p  bit i: consumer i dequeues the head. Legal only when v_o[i]=1.
- err_o  output  1  sticky: a valid input arrived with a non-one-hot select.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - All FIFOs empty, v_o=0, err_o=0.
  - data_o contents are don't-care; bench must not check them while v_o=0.
  - Reset mid-transfer discards all buffered words. No output glitches to valid during reset.
- Channel FIFO (per channel i):
  - 2 entries, read/write pointers plus a count of 0..2.
  - Pointers wrap from 1 to 0.
  - full_i = (count_i==2). v_o[i] = (count_i!=0).
  - Head is registered storage; no combinational path from data_i to data_o.
- ready_o:
  - Legal select (exactly one bit set): ready_o = ~full of the selected channel.
  - Illegal select (zero bits or more than one bit set): ready_o = 1.
  - ready_o depends only on sel_one_hot_i and FIFO state, never on yumi_i or v_i.
- Enqueue: when v_i & ready_o & legal select, data_i is written to the selected channel's FIFO. The word is visible on v_o/data_o the next cycle (latency 1).
- Dequeue: yumi_i[i] pops channel i at the clock edge. The next head appears the following cycle.
- Simultaneous enqueue and dequeue on the same channel:
  - count 0: enqueue only, no pop possible.
  - count 1: count stays 1; the new word becomes head after the pop.
  - count 2: ready_o=0 for that channel, so no enqueue. A full FIFO does not accept a word in the same cycle it is popped.
- Enqueue and dequeue on different channels in the same cycle are fully independent.
- Illegal select handling:
  - When v_i=1 and the select is not one-hot, the word is consumed (ready_o=1) and dropped, and err_o is set.
  - err_o holds at 1 until reset.
  - An illegal select with v_i=0 has no effect.
- Ordering: words for each channel leave in acceptance order. No ordering is defined between channels.
- Assertion (simulation only): fires on yumi_i[i] & ~v_o[i].

Test Plan:
- Reset then idle:
  - Drive reset_n_i=0 mid-cycle with v_i=0.
  - Required: v_o=00 and err_o=0 immediately (asynchronously), and they stay so after release.
  - Required: ready_o=1 for sel=01 and for sel=10.
- Single routing:
  - v_i=1, sel=10, data_i=62'h2A5A5A5A5A5A5A5, one cycle.
  - Required: next cycle v_o=10, data_o[123:62]=62'h2A5A5A5A5A5A5A5, v_o[0]=0.
  - yumi_i=10 gives v_o=00 on the following cycle.
- Fill and back-pressure:
  - Send 1, 2, 3 to channel 0 on consecutive cycles with no yumi.
  - Required: words 1 and 2 accepted; ready_o=0 on the third cycle; word 3 is held by the producer.
  - Pulse yumi_i[0]: ready_o is still 0 that cycle and becomes 1 the next cycle. Word 3 is then accepted.
  - Drain order must be 1, 2, 3.
- Concurrent traffic:
  - Alternate sel=01 and sel=10 with data 0..9 while both yumi_i are held at 1 whenever v_o is set.
  - Required: channel 0 outputs 0, 2, 4, 6, 8 and channel 1 outputs 1, 3, 5, 7, 9, with no stalls.
- Illegal select:
  - v_i=1, sel=11, data=5.
  - Required: ready_o=1; err_o=1 from the next cycle; v_o is unchanged.
  - Then v_i=1, sel=00: err_o stays 1, no enqueue. Only reset clears err_o.
- Reset mid-operation:
  - Both FIFOs hold 2 words; assert reset_n_i=0 for 1 cycle.
  - Required: v_o=00 immediately; after release, new words route normally with no stale words emerging.
